// File: rtl/x_multdiv_pkg.sv
// x_multdiv_pkg: shared constants and types for the execute-stage mul/div unit.
//   - opcode / ALU-op fields that identify mul and div in IR_X
//   - controller state encoding
//   - rstatus codes reported for a faulting mul (4) or div (5)
package x_multdiv_pkg;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] ALU_MUL  = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    localparam logic [31:0] RSTATUS_MUL = 32'd4;
    localparam logic [31:0] RSTATUS_DIV = 32'd5;

    // Step counter width; large enough for the 32-step divide.
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } md_state_e;

endpackage

// File: rtl/x_multdiv_ctrl_md_iter_core.sv
// md_iter_core: shared 66-bit iterative datapath for signed multiply and divide.
//   Multiply: radix-4 Booth on {acc[32:0], multiplier[31:0], guard}.
//   Divide:   non-restoring on {rem[32:0], quotient[31:0], unused bit},
//             operating on magnitudes with the sign applied at the end.
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high clear
//   load, ld_div        latch op_a/op_b and the op type
//   op_a, op_b          multiplicand/dividend, multiplier/divisor
//   step_mul, step_div  advance one iteration
//   finalize            asserted alongside the last step; captures the result
//   product, overflow   low 32 bits of the product, product[63:31] not uniform
//   quotient, div_zero  signed quotient (0 on divide-by-zero), divisor was 0
module md_iter_core
    import x_multdiv_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic        ld_div,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        step_mul,
    input  logic        step_div,
    input  logic        finalize,
    output logic [31:0] product,
    output logic        overflow,
    output logic [31:0] quotient,
    output logic        div_zero
);

    logic [65:0] rr;
    logic [31:0] mcand;     // signed multiplicand, or divisor magnitude
    logic        neg;       // quotient must be negated
    logic        dz_l;      // divisor was zero at launch

    logic [31:0] abs_a, abs_b;
    assign abs_a = op_a[31] ? (32'd0 - op_a) : op_a;
    assign abs_b = op_b[31] ? (32'd0 - op_b) : op_b;

    // Booth step: add 0/+-M/+-2M selected by {q1, q0, guard}, then >>> 2.
    // The sum is kept 35 bits wide so +-2M never overflows the accumulator.
    logic [34:0] m35, addend, sum;
    logic [65:0] mul_nxt;
    always_comb begin
        m35 = {{3{mcand[31]}}, mcand};
        case (rr[2:0])
            3'b001, 3'b010: addend = m35;
            3'b011:         addend = m35 << 1;
            3'b100:         addend = 35'd0 - (m35 << 1);
            3'b101, 3'b110: addend = 35'd0 - m35;
            default:        addend = '0;
        endcase
        sum     = {{2{rr[65]}}, rr[65:33]} + addend;
        mul_nxt = {sum[34:2], sum[1:0], rr[32:3], rr[2]};
    end

    // Non-restoring step: subtract if the partial remainder is non-negative,
    // add otherwise; the new quotient bit is 1 when the result is non-negative.
    // With this form the quotient bits come out final; only the remainder would
    // need a correction, and the remainder is not used.
    logic [33:0] shifted, t;
    logic [65:0] div_nxt;
    always_comb begin
        shifted = {rr[65:33], rr[32]};
        if (!rr[65]) t = shifted - {2'b00, mcand};
        else         t = shifted + {2'b00, mcand};
        div_nxt = {t[32:0], rr[31:1], ~t[32], 1'b0};
    end

    logic [31:0] q_mag;
    logic [32:0] p_hi;      // product bits [63:31] after the final step
    assign q_mag = div_nxt[32:1];
    assign p_hi  = {mul_nxt[64:33], mul_nxt[32]};

    always_ff @(posedge clock) begin
        if (reset) begin
            rr       <= '0;
            mcand    <= '0;
            neg      <= 1'b0;
            dz_l     <= 1'b0;
            product  <= '0;
            overflow <= 1'b0;
            quotient <= '0;
            div_zero <= 1'b0;
        end else begin
            if (load) begin
                rr    <= {33'd0, (ld_div ? abs_a : op_b), 1'b0};
                mcand <= ld_div ? abs_b : op_a;
                neg   <= ld_div & (op_a[31] ^ op_b[31]);
                dz_l  <= ld_div & (op_b == 32'd0);
            end else if (step_mul) begin
                rr <= mul_nxt;
            end else if (step_div) begin
                rr <= div_nxt;
            end

            if (finalize && step_mul) begin
                product  <= mul_nxt[32:1];
                overflow <= !((&p_hi) || !(|p_hi));
            end
            if (finalize && step_div) begin
                quotient <= dz_l ? 32'd0 : (neg ? (32'd0 - q_mag) : q_mag);
                div_zero <= dz_l;
            end
        end
    end

endmodule

// File: rtl/x_multdiv_ctrl.sv
// x_multdiv_ctrl: execute-stage mul/div controller. Decodes mul/div in X,
// launches the iterative core on the bypassed operands, freezes F/D/X with
// stall while it runs, and presents a one-cycle result_valid.
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   IR_X              instruction in X
//   op_A, op_B        bypassed rs / rt operands, sampled only at launch
//   flush             kill the in-flight op / block launch
//   stall             freeze PC, F/D, D/X
//   busy              iterating (MUL or DIV)
//   result            product low word or quotient
//   result_valid      high in DONE only
//   exception         mul overflow or divide-by-zero, qualified by result_valid
//   is_div            op type of the result (rstatus 4 = mul, 5 = div)
module x_multdiv_ctrl
    import x_multdiv_pkg::*;
#(
    parameter int MUL_STEPS = 16,
    parameter int DIV_STEPS = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] IR_X,
    input  logic [31:0] op_A,
    input  logic [31:0] op_B,
    input  logic        flush,
    output logic        stall,
    output logic        busy,
    output logic [31:0] result,
    output logic        result_valid,
    output logic        exception,
    output logic        is_div
);

    md_state_e        state;
    logic [CNT_W-1:0] cnt;
    logic             op_q;

    logic unused_ir;
    assign unused_ir = ^{IR_X[26:7], IR_X[1:0]};

    logic is_md, dec_div, launch, last_mul, last_div;
    assign dec_div  = (IR_X[6:2] == ALU_DIV);
    assign is_md    = (IR_X[31:27] == OP_RTYPE) & ((IR_X[6:2] == ALU_MUL) | dec_div);
    assign launch   = (state == ST_IDLE) & is_md & !flush;
    assign last_mul = (state == ST_MUL) & (cnt == CNT_W'(MUL_STEPS - 1));
    assign last_div = (state == ST_DIV) & (cnt == CNT_W'(DIV_STEPS - 1));

    // Launch stalls in the same cycle so the D/X latch holds the operands' source.
    assign busy         = (state == ST_MUL) | (state == ST_DIV);
    assign stall        = launch | (busy & !flush);
    assign result_valid = (state == ST_DONE) & !flush;
    assign is_div       = op_q;

    logic [31:0] product, quotient;
    logic        overflow, div_zero;

    md_iter_core u_core (
        .clock    (clock),
        .reset    (reset),
        .load     (launch),
        .ld_div   (dec_div),
        .op_a     (op_A),
        .op_b     (op_B),
        .step_mul (state == ST_MUL),
        .step_div (state == ST_DIV),
        .finalize ((last_mul | last_div) & !flush),
        .product  (product),
        .overflow (overflow),
        .quotient (quotient),
        .div_zero (div_zero)
    );

    assign result    = op_q ? quotient : product;
    assign exception = op_q ? div_zero : overflow;

    // DONE always returns to IDLE so the instruction still held in X is not
    // relaunched; the next mul/div launches from IDLE one cycle later.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            op_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (launch) begin
                        state <= dec_div ? ST_DIV : ST_MUL;
                        cnt   <= '0;
                        op_q  <= dec_div;
                    end
                end
                ST_MUL: begin
                    if (flush) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else if (last_mul) state <= ST_DONE;
                    else                   cnt   <= cnt + 1'b1;
                end
                ST_DIV: begin
                    if (flush) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else if (last_div) state <= ST_DONE;
                    else                   cnt   <= cnt + 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_x_multdiv_ctrl.sv
// Directed bench for x_multdiv_ctrl. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge. Cycle 0 is the cycle
// the mul/div instruction first sits in X with the unit idle.
module tb_x_multdiv_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] IR_X  = '0;
    logic [31:0] op_A  = '0;
    logic [31:0] op_B  = '0;
    logic        flush = 1'b0;
    logic        stall, busy, result_valid, exception, is_div;
    logic [31:0] result;

    int tests = 0;
    int fails = 0;

    localparam logic [31:0] IR_MUL = {25'd0, 5'b00110, 2'b00};
    localparam logic [31:0] IR_DIV = {25'd0, 5'b00111, 2'b00};
    localparam logic [31:0] IR_NOP = 32'd0;

    x_multdiv_ctrl dut (
        .clock        (clock),
        .reset        (reset),
        .IR_X         (IR_X),
        .op_A         (op_A),
        .op_B         (op_B),
        .flush        (flush),
        .stall        (stall),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .exception    (exception),
        .is_div       (is_div)
    );

    always #5 clock = ~clock;

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // Runs one op from launch to the DONE edge, checking the stall/busy/valid
    // profile cycle by cycle and the result in the DONE cycle. Leaves X holding
    // a nop unless the caller replaces it before the next edge.
    task automatic run_md(input string nm, input logic [31:0] ir, input logic [31:0] a,
                          input logic [31:0] b, input int lat, input logic [31:0] exp_res,
                          input logic exp_exc, input logic exp_div, input bit scramble);
        bit bad = 0;
        IR_X = ir; op_A = a; op_B = b;
        for (int c = 0; c <= lat; c++) begin
            @(negedge clock);
            if (stall !== (c < lat) || result_valid !== (c == lat) ||
                busy !== (c >= 1 && c < lat)) begin
                if (!bad) $display("FAIL %s profile: cycle %0d stall=%b busy=%b valid=%b", nm, c,
                                   stall, busy, result_valid);
                bad = 1;
            end
            if (c == lat) begin
                tests++;
                if (result !== exp_res) begin
                    fails++;
                    $display("FAIL %s result: got %h want %h", nm, result, exp_res);
                end
                tests++;
                if (exception !== exp_exc) begin
                    fails++;
                    $display("FAIL %s exception: got %b want %b", nm, exception, exp_exc);
                end
                tests++;
                if (is_div !== exp_div) begin
                    fails++;
                    $display("FAIL %s is_div: got %b want %b", nm, is_div, exp_div);
                end
            end
            next_cycle();
            if (scramble && c == 2) begin
                op_A = 32'hDEAD_BEEF;
                op_B = 32'h0000_0003;
            end
        end
        IR_X = IR_NOP;
        tests++;
        if (bad) fails++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) next_cycle();
        reset = 1'b0;
        @(negedge clock);
        tests++;
        if ({stall, busy, result_valid, exception, is_div} !== 5'b0 || result !== 32'd0) begin
            fails++;
            $display("FAIL reset: stall=%b busy=%b valid=%b exc=%b is_div=%b result=%h want all 0",
                     stall, busy, result_valid, exception, is_div, result);
        end
        next_cycle();
    endtask

    task automatic test_mul();
        run_md("mul_7x-6",     IR_MUL, 32'd7,         32'hFFFF_FFFA, 17, 32'hFFFF_FFD6, 1'b0, 1'b0, 0);
        run_md("mul_ovf",      IR_MUL, 32'h0001_0000, 32'h0001_0000, 17, 32'h0000_0000, 1'b1, 1'b0, 0);
        run_md("mul_max_x1",   IR_MUL, 32'h7FFF_FFFF, 32'd1,         17, 32'h7FFF_FFFF, 1'b0, 1'b0, 0);
        run_md("mul_min_x1",   IR_MUL, 32'h8000_0000, 32'd1,         17, 32'h8000_0000, 1'b0, 1'b0, 0);
        run_md("mul_min_xm1",  IR_MUL, 32'h8000_0000, 32'hFFFF_FFFF, 17, 32'h8000_0000, 1'b1, 1'b0, 0);
    endtask

    task automatic test_div();
        run_md("div_-7/2",     IR_DIV, 32'hFFFF_FFF9, 32'd2,         33, 32'hFFFF_FFFD, 1'b0, 1'b1, 0);
        run_md("div_5/0",      IR_DIV, 32'd5,         32'd0,         33, 32'h0000_0000, 1'b1, 1'b1, 0);
        run_md("div_min/-1",   IR_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 1'b0, 1'b1, 0);
    endtask

    task automatic test_back_to_back();
        bit bad = 0;
        // Second op sits in X right after the first DONE edge: launch at 18,
        // valid at 18 + 33 = 51.
        run_md("b2b_mul", IR_MUL, 32'd3,   32'd4,         17, 32'd12,        1'b0, 1'b0, 0);
        run_md("b2b_div", IR_DIV, 32'd100, 32'hFFFF_FFF9, 33, 32'hFFFF_FFF2, 1'b0, 1'b1, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            if (stall !== 1'b0 || result_valid !== 1'b0 || busy !== 1'b0) bad = 1;
            next_cycle();
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL b2b_idle: stall=%b busy=%b valid=%b want 0 0 0", stall, busy, result_valid);
        end
    endtask

    task automatic test_flush();
        bit seen = 0;
        IR_X = IR_DIV; op_A = 32'hFFFF_FFF9; op_B = 32'd2;
        repeat (5) next_cycle();
        flush = 1'b1;                       // cycle 5
        @(negedge clock);
        tests++;
        if (stall !== 1'b0 || result_valid !== 1'b0) begin
            fails++;
            $display("FAIL flush_cycle: stall=%b valid=%b want 0 0", stall, result_valid);
        end
        next_cycle();
        flush = 1'b0; IR_X = IR_NOP;        // cycle 6
        @(negedge clock);
        tests++;
        if (busy !== 1'b0 || stall !== 1'b0) begin
            fails++;
            $display("FAIL flush_idle: busy=%b stall=%b want 0 0", busy, stall);
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (result_valid !== 1'b0) seen = 1;
        end
        tests++;
        if (seen) begin
            fails++;
            $display("FAIL flush_no_valid: result_valid pulsed, want none");
        end
        next_cycle();
        run_md("div_scramble", IR_DIV, 32'd100, 32'd7, 33, 32'd14, 1'b0, 1'b1, 1);
    endtask

    task automatic test_flush_idle();
        IR_X = IR_MUL; op_A = 32'd2; op_B = 32'd2; flush = 1'b1;
        @(negedge clock);
        tests++;
        if (stall !== 1'b0) begin
            fails++;
            $display("FAIL flush_blocks_launch stall: got %b want 0", stall);
        end
        next_cycle();
        flush = 1'b0; IR_X = IR_NOP;
        @(negedge clock);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL flush_blocks_launch busy: got %b want 0", busy);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_mul();
        bit seen = 0;
        IR_X = IR_MUL; op_A = 32'hFFFF_FFFD; op_B = 32'hFFFF_FFFB;
        repeat (10) next_cycle();
        reset = 1'b1;                       // cycle 10
        flush = 1'b1;                       // reset must win
        next_cycle();
        reset = 1'b0; flush = 1'b0; IR_X = IR_NOP;
        @(negedge clock);
        tests++;
        if ({stall, busy, result_valid, exception, is_div} !== 5'b0 || result !== 32'd0) begin
            fails++;
            $display("FAIL reset_mid: stall=%b busy=%b valid=%b exc=%b is_div=%b result=%h want all 0",
                     stall, busy, result_valid, exception, is_div, result);
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (result_valid !== 1'b0) seen = 1;
        end
        tests++;
        if (seen) begin
            fails++;
            $display("FAIL reset_mid_no_valid: result_valid pulsed, want none");
        end
        next_cycle();
        run_md("mul_after_reset", IR_MUL, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 17, 32'd15, 1'b0, 1'b0, 0);
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_back_to_back();
        test_flush();
        test_flush_idle();
        test_reset_mid_mul();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/x_multdiv_ctrl.md
Name: x_multdiv_ctrl

Overview:
- Execute-stage consumer of the bypassed ALU operands.
- When the instruction in X is `mul` or `div`, it latches the forwarded operands, runs an iterative signed multiply (radix-4 Booth, 16 steps) or divide (non-restoring, 32 steps), and holds `stall` high to freeze F/D/X.
- It returns a one-cycle `result_valid` with `result` and `exception`. The X/M latch captures these in place of the ALU output.

Parameters:
- `MUL_STEPS`, 16, Booth radix-4 iterations for a 32x32 multiply.
- `DIV_STEPS`, 32, non-restoring divide iterations.

Ports:
- `clock`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high; all state cleared on the edge it is sampled high
- `IR_X`  in  32  instruction currently in X
- `op_A`  in  32  bypassed operand A (rs); multiplicand / dividend
- `op_B`  in  32  bypassed operand B (rt); multiplier / divisor
- `flush`  in  1  kill in-flight operation (control redirect)
- `stall`  out  1  freeze PC, F/D and D/X latches, hold `IR_X`
- `busy`  out  1  state is MUL or DIV
- `result`  out  32  low 32 bits of product, or quotient
- `result_valid`  out  1  high exactly in DONE
- `exception`  out  1  mul overflow or divide-by-zero; valid with `result_valid`
- `is_div`  out  1  op type of the completing result (selects rstatus code 4 = mul, 5 = div)

Behaviour:
- Decode: `is_md` = (`IR_X[31:27]` == 00000) & (`IR_X[6:2]` ∈ {00110 mul, 00111 div}).
- States: IDLE, MUL, DIV, DONE. Reset → IDLE, counter = 0, operand/accumulator registers = 0; outputs `stall` = `busy` = `result_valid` = `exception` = `is_div` = 0, `result` = 0.
- IDLE:
  - If `is_md` & !`flush`: `stall` = 1 combinationally this cycle; latch `op_A`, `op_B` and the op type; go to MUL or DIV; counter = 0.
  - Otherwise `stall` = 0.
- MUL:
  - One Booth radix-4 step per cycle on a 66-bit {acc, multiplier, guard} register; `stall` = 1, `busy` = 1.
  - After step `MUL_STEPS`-1, go to DONE.
- DIV:
  - Operate on absolute values; one non-restoring step per cycle; `stall` = 1.
  - After step `DIV_STEPS`-1, apply the final remainder correction (remainder is discarded) and the sign fixup (quotient negative iff signs differ); go to DONE.
- DONE:
  - `stall` = 0, `result_valid` = 1. The pipeline advances on this edge and the X/M latch captures `result` and `exception`.
  - Next state is IDLE unconditionally. An `is_md` instruction arriving in X is launched from IDLE on the following cycle, never directly from DONE, so the completing instruction is never relaunched.
- Latency (cycle 0 = launch cycle in IDLE):
  - mul: `stall` high cycles 0..16, `result_valid` in cycle 17.
  - div: `stall` high cycles 0..32, `result_valid` in cycle 33.
- mul overflow: `exception` = 1 iff product bits [63:31] are not all equal. `result` is still the low 32 bits.
- div by zero: detected at launch; the op still runs the full `DIV_STEPS` for fixed latency. `result` = 0, `exception` = 1.
- `INT_MIN` / -1: `result` = 0x80000000, `exception` = 0.
- `flush`:
  - In IDLE, blocks launch.
  - In MUL/DIV/DONE, forces IDLE on the next edge: `stall` = 0 that cycle, `result_valid` = 0.
- `reset` mid-operation: IDLE on the next edge, no `result_valid` produced. `reset` has priority over `flush`.
- `op_A`/`op_B` are sampled only in the launch cycle; later changes are ignored.

Decomposition:
- Shared package:
  - opcode/ALU-op constants (`OP_RTYPE` = 00000, `ALU_MUL` = 00110, `ALU_DIV` = 00111)
  - state enum encoding
  - rstatus codes (`RSTATUS_MUL` = 4, `RSTATUS_DIV` = 5)
- One sub-module, `md_iter_core`: the shared 66-bit shift/accumulate datapath. It takes `step_mul`, `step_div`, `load`, `finalize` and exposes product/quotient plus overflow. The controller (FSM, counter, stall, decode) stays in `x_multdiv_ctrl`.

Test Plan:
- mul 7 × -6 launched in cycle 0 → `stall` high cycles 0..16; cycle 17 `result_valid` = 1, `result` = 0xFFFFFFD6, `exception` = 0, `is_div` = 0.
- mul 0x00010000 × 0x00010000 → `result` = 0x00000000, `exception` = 1 in cycle 17; also 0x7FFFFFFF × 1 → 0x7FFFFFFF, `exception` = 0.
- div -7 ÷ 2 → cycle 33 `result` = 0xFFFFFFFD (-3), `exception` = 0, `is_div` = 1; div 5 ÷ 0 → `result` = 0, `exception` = 1 at cycle 33.
- Back-to-back mul, then div, in consecutive instructions → first `result_valid` at cycle 17, second launch at cycle 18, its `result_valid` at cycle 51; no duplicate launch.
- `flush` asserted in cycle 5 of a div → cycle 6 in IDLE, `stall` = 0, no `result_valid` pulse; `op_A`/`op_B` changed during the op have no effect on a separate run.
- `reset` asserted in cycle 10 of a mul → next cycle all outputs 0, state IDLE; a new mul then completes normally with the correct latency.
